// File: rtl/system1_input0_edge_if.sv
// Avalon-MM slave bus bundle for the system1 input PIO.
// The slave modport is used by the PIO; the master modport by whatever drives the bus.
interface system1_input0_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  read_n,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output read_n,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/system1_input0_edge.sv
// Parallel input PIO: two-flop synchroniser, per-bit edge capture (W1C),
// maskable level interrupt and a 1-cycle-latency Avalon-MM register file.
module system1_input0_edge #(
  parameter int          WIDTH          = 32,
  parameter int          EDGE_TYPE      = 0,
  parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  system1_input0_edge_if.slave bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edge_capture;
  logic [WIDTH-1:0] r_irq_mask;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_edge_capture_next;
  logic [WIDTH-1:0] w_irq_mask_next;
  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_data_ext;
  logic [31:0]      w_mask_ext;
  logic [31:0]      w_edge_ext;
  logic [31:0]      w_rd_mux;

  // Edge sense is fixed at elaboration; each bit gets only the detector it needs.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_det
      if (EDGE_TYPE == 0) begin : g_rise
        assign w_det[gi] = r_sync2[gi] & ~r_prev[gi];
      end else if (EDGE_TYPE == 1) begin : g_fall
        assign w_det[gi] = ~r_sync2[gi] & r_prev[gi];
      end else begin : g_any
        assign w_det[gi] = r_sync2[gi] ^ r_prev[gi];
      end
    end
  endgenerate

  assign w_wr = bus.chipselect & ~bus.write_n;
  assign w_rd = bus.chipselect & ~bus.read_n;

  always_comb begin
    w_clr           = '0;
    w_irq_mask_next = r_irq_mask;
    if (w_wr && bus.address == ADDR_EDGE) begin
      w_clr = bus.writedata[WIDTH-1:0];
    end
    if (w_wr && bus.address == ADDR_MASK) begin
      w_irq_mask_next = bus.writedata[WIDTH-1:0];
    end
  end

  // A new edge in the same cycle as a clear of that bit keeps the bit set.
  assign w_edge_capture_next = (r_edge_capture & ~w_clr) | w_det;

  // Registers are zero-extended onto the 32-bit bus.
  always_comb begin
    w_data_ext             = '0;
    w_mask_ext             = '0;
    w_edge_ext             = '0;
    w_data_ext[WIDTH-1:0]  = r_sync2;
    w_mask_ext[WIDTH-1:0]  = r_irq_mask;
    w_edge_ext[WIDTH-1:0]  = r_edge_capture;
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA: w_rd_mux = w_data_ext;
      ADDR_MASK: w_rd_mux = w_mask_ext;
      ADDR_EDGE: w_rd_mux = w_edge_ext;
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1        <= '0;
      r_sync2        <= '0;
      r_prev         <= '0;
      r_edge_capture <= '0;
      r_irq_mask     <= IRQ_MASK_RESET[WIDTH-1:0];
      r_readdata     <= '0;
      r_irq          <= 1'b0;
    end else begin
      r_sync1        <= in_port;
      r_sync2        <= r_sync1;
      r_prev         <= r_sync2;
      r_edge_capture <= w_edge_capture_next;
      r_irq_mask     <= w_irq_mask_next;
      r_readdata     <= w_rd ? w_rd_mux : 32'h0;
      r_irq          <= |(w_edge_capture_next & w_irq_mask_next);
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_system1_input0_edge.sv
// Scoreboard bench: three PIO variants (rising/32b, falling/32b, any/8b) share one
// stimulus stream; a sample-history model predicts readdata and irq every cycle.
module tb_system1_input0_edge;

  localparam int          P_W  [3] = '{32, 32, 8};
  localparam int          P_ET [3] = '{0, 1, 2};
  localparam logic [31:0] P_MR [3] = '{32'h0, 32'h0, 32'h5};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_port;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  system1_input0_edge_if if0 ();
  system1_input0_edge_if if1 ();
  system1_input0_edge_if if2 ();

  system1_input0_edge #(.WIDTH(32), .EDGE_TYPE(0), .IRQ_MASK_RESET(32'h0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(if0), .in_port(in_port), .irq(irq0));
  system1_input0_edge #(.WIDTH(32), .EDGE_TYPE(1), .IRQ_MASK_RESET(32'h0)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(if1), .in_port(in_port), .irq(irq1));
  system1_input0_edge #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_MASK_RESET(32'h5)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(if2), .in_port(in_port[7:0]), .irq(irq2));

  typedef struct packed {
    logic        is_rd;
    logic [1:0]  addr;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [2:0]  irq;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // ---------------- reference model ----------------
  // h[0] is the in_port value sampled at the latest edge, h[1] the one before, ...
  // The DATA register exposes the sample from two edges back; an edge is judged
  // between that sample and the one before it.
  logic [31:0] h [3];
  logic [31:0] m_cap  [3];
  logic [31:0] m_mask [3];
  logic [31:0] m_rd   [3];
  logic [2:0]  m_irq;
  logic [31:0] wm, s2, pv, det, clr;
  exp_t        e;

  initial begin
    for (int k = 0; k < 3; k++) h[k] = 32'h0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      wm = (P_W[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << P_W[k]) - 32'd1);
      m_rd[k] = 32'h0;
      if (!reset_n) begin
        m_cap[k]  = 32'h0;
        m_mask[k] = P_MR[k] & wm;
      end else begin
        s2 = h[1] & wm;
        pv = h[2] & wm;
        if (P_ET[k] == 0)      det = s2 & ~pv;
        else if (P_ET[k] == 1) det = ~s2 & pv;
        else                   det = s2 ^ pv;
        if (if0.chipselect && !if0.read_n) begin
          case (if0.address)
            2'd0:    m_rd[k] = s2;
            2'd2:    m_rd[k] = m_mask[k];
            2'd3:    m_rd[k] = m_cap[k];
            default: m_rd[k] = 32'h0;
          endcase
        end
        clr = 32'h0;
        if (if0.chipselect && !if0.write_n) begin
          if (if0.address == 2'd2) m_mask[k] = if0.writedata & wm;
          if (if0.address == 2'd3) clr = if0.writedata & wm;
        end
        m_cap[k] = (m_cap[k] & ~clr) | det;
      end
      m_irq[k] = reset_n && ((m_cap[k] & m_mask[k]) != 32'h0);
    end
    if (!reset_n) begin
      h[0] = 32'h0; h[1] = 32'h0; h[2] = 32'h0;
    end else begin
      h[2] = h[1]; h[1] = h[0]; h[0] = in_port;
    end
    e.is_rd = reset_n && if0.chipselect && !if0.read_n;
    e.addr  = if0.address;
    e.r0    = m_rd[0];
    e.r1    = m_rd[1];
    e.r2    = m_rd[2];
    e.irq   = m_irq;
    q.push_back(e);
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  exp_t g;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      g = q.pop_front();
      chk("u0.readdata", if0.readdata, g.r0);
      chk("u1.readdata", if1.readdata, g.r1);
      chk("u2.readdata", if2.readdata, g.r2);
      chk("u0.irq", {31'h0, irq0}, {31'h0, g.irq[0]});
      chk("u1.irq", {31'h0, irq1}, {31'h0, g.irq[1]});
      chk("u2.irq", {31'h0, irq2}, {31'h0, g.irq[2]});
      if (g.is_rd)
        $display("read addr=%0d u0=%h u1=%h u2=%h irq=%b%b%b",
                 g.addr, if0.readdata, if1.readdata, if2.readdata, irq2, irq1, irq0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic cs, input logic rd, input logic wr,
                     input logic [1:0] addr, input logic [31:0] wd);
    @(negedge clk);
    if0.chipselect = cs; if0.read_n = ~rd; if0.write_n = ~wr; if0.address = addr; if0.writedata = wd;
    if1.chipselect = cs; if1.read_n = ~rd; if1.write_n = ~wr; if1.address = addr; if1.writedata = wd;
    if2.chipselect = cs; if2.read_n = ~rd; if2.write_n = ~wr; if2.address = addr; if2.writedata = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic rd(input logic [1:0] a);
    bus(1'b1, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    reset_n = 1'b0;
    in_port = 32'h0;
    if0.chipselect = 0; if0.read_n = 1; if0.write_n = 1; if0.address = 0; if0.writedata = 0;
    if1.chipselect = 0; if1.read_n = 1; if1.write_n = 1; if1.address = 0; if1.writedata = 0;
    if2.chipselect = 0; if2.read_n = 1; if2.write_n = 1; if2.address = 0; if2.writedata = 0;
    idle(3);
    @(negedge clk) reset_n = 1'b1;
    idle(3);
    for (int a = 0; a < 4; a++) rd(2'(a));

    // Rising pattern 0xA5, then mask/clear interplay.
    @(negedge clk) in_port = 32'h0000_00A5;
    idle(1);
    rd(2'd0);
    idle(3);
    rd(2'd0);
    rd(2'd3);
    wr(2'd2, 32'h1);
    idle(2);
    wr(2'd3, 32'h1);
    idle(1);
    rd(2'd3);

    // Bit 0 rises in the same cycle it is written-1-to-clear.
    @(negedge clk) in_port = 32'h0000_00A4;
    idle(4);
    wr(2'd3, 32'h1);
    @(negedge clk) in_port = 32'h0000_00A5;
    idle(1);
    wr(2'd3, 32'h1);
    rd(2'd3);
    idle(2);

    // Falling / any-edge patterns.
    wr(2'd3, 32'hFFFF_FFFF);
    @(negedge clk) in_port = 32'h0000_00FF;
    idle(4);
    wr(2'd3, 32'hFFFF_FFFF);
    @(negedge clk) in_port = 32'h0000_000F;
    idle(4);
    rd(2'd3);
    wr(2'd3, 32'hFFFF_FFFF);
    @(negedge clk) in_port = 32'h0000_00F0;
    idle(4);
    rd(2'd3);

    // Randomised traffic, including read+write of the same register in one cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) in_port = $urandom;
      case ($urandom_range(0, 4))
        0:       bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        1:       bus(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
        2:       bus(1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom);
        3:       bus(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
        default: bus(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
      endcase
    end

    // Bus held high through a mid-operation reset.
    wr(2'd2, 32'hFFFF_FFFF);
    @(negedge clk) in_port = 32'hFFFF_FFFF;
    idle(3);
    @(negedge clk) reset_n = 1'b0;
    idle(2);
    @(negedge clk) reset_n = 1'b1;
    rd(2'd3);
    rd(2'd3);
    rd(2'd3);
    rd(2'd2);
    rd(2'd0);
    idle(3);

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
